cache_way_sel_pipe: RTL and testbench

N-way parametrised successor to the cache's 2:1 line-data and memory-address selects. One cycle, a captured beat carries every way's cache line and line address plus a way select. The block selects one way and delivers the chosen {data, addr} pair through a registered valid/ready output stage with a skid slot, so it keeps full throughput under backpressure. It sits between the way arrays / tag compare and the datapath or memory-side arbiter; one instance covers both the data path and the address path.

---
 rtl/cache_sel_pkg.sv | 39 +++
 rtl/way_select_comb.sv | 32 +++
 rtl/cache_way_sel_pipe.sv | 160 ++++++++++++++++
 tb/tb_cache_way_sel_pipe.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_sel_pkg.sv
// cache_sel_pkg
//   Shared types and helpers for the cache way-select blocks.
//   sel_mode_e    : how a way select is encoded (binary index or one-hot hit vector)
//   ERR_CNT_W     : width of the saturating illegal-select counter
//   onehot_to_idx : one-hot vector -> {index, illegal}
package cache_sel_pkg;

   typedef enum logic {
      SEL_BINARY = 1'b0,
      SEL_ONEHOT = 1'b1
   } sel_mode_e;

   localparam int ERR_CNT_W = 8;
   localparam int MAX_WAYS  = 256;

   typedef struct packed {
      logic [7:0] idx;
      logic       illegal;
   } sel_dec_t;

   // Lowest set bit wins; zero or multiple bits set is flagged illegal.
   // With no bit set the index falls back to way 0.
   function automatic sel_dec_t onehot_to_idx(input logic [MAX_WAYS-1:0] hot,
                                              input int ways);
      sel_dec_t res;
      int       cnt;
      res = '0;
      cnt = 0;
      for (int i = MAX_WAYS-1; i >= 0; i--) begin
         if (i < ways && hot[i]) begin
            res.idx = 8'(i);
            cnt     = cnt + 1;
         end
      end
      res.illegal = (cnt != 1);
      return res;
   endfunction

endpackage

// File: rtl/way_select_comb.sv
// way_select_comb
//   Combinational WAYS:1 select of one way's {data, addr} slice.
//   way_data_i : flattened lines, way i at [i*WIDTH +: WIDTH]
//   way_addr_i : flattened addresses, way i at [i*AWIDTH +: AWIDTH]
//   idx_i      : binary way index (out-of-range index returns way 0)
//   data_o     : selected line, bit-exact
//   addr_o     : selected address, bit-exact
module way_select_comb #(
   parameter  int WIDTH  = 256,
   parameter  int AWIDTH = 32,
   parameter  int WAYS   = 2,
   localparam int IDXW   = $clog2(WAYS)
) (
   input  logic [WAYS*WIDTH-1:0]  way_data_i,
   input  logic [WAYS*AWIDTH-1:0] way_addr_i,
   input  logic [IDXW-1:0]        idx_i,
   output logic [WIDTH-1:0]       data_o,
   output logic [AWIDTH-1:0]      addr_o
);

   always_comb begin
      data_o = way_data_i[0 +: WIDTH];
      addr_o = way_addr_i[0 +: AWIDTH];
      for (int i = 1; i < WAYS; i++) begin
         if (idx_i == IDXW'(i)) begin
            data_o = way_data_i[i*WIDTH +: WIDTH];
            addr_o = way_addr_i[i*AWIDTH +: AWIDTH];
         end
      end
   end

endmodule

// File: rtl/cache_way_sel_pipe.sv
// cache_way_sel_pipe
//   Selects one way's {line, address} from a captured beat and delivers it
//   through a registered valid/ready output stage with one skid slot.
//   clk, rst_n           : clock, async active-low reset
//   in_valid / in_ready  : input handshake (in_ready is registered)
//   way_data / way_addr  : flattened per-way lines and addresses
//   sel                  : way select, binary index or one-hot per ONEHOT
//   out_valid / out_ready: output handshake
//   out_data/addr/way    : selected line, address and binary way index
//   sel_err / err_count  : sticky illegal-select flag, saturating count
module cache_way_sel_pipe
   import cache_sel_pkg::*;
#(
   parameter  int WIDTH  = 256,
   parameter  int AWIDTH = 32,
   parameter  int WAYS   = 2,
   parameter  int ONEHOT = 0,
   localparam int SELW   = (ONEHOT != 0) ? WAYS : $clog2(WAYS),
   localparam int IDXW   = $clog2(WAYS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WAYS*WIDTH-1:0]  way_data,
   input  logic [WAYS*AWIDTH-1:0] way_addr,
   input  logic [SELW-1:0]       sel,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic [AWIDTH-1:0]     out_addr,
   output logic [IDXW-1:0]       out_way,
   output logic                  sel_err,
   output logic [ERR_CNT_W-1:0]  err_count
);

   localparam sel_mode_e MODE = (ONEHOT != 0) ? SEL_ONEHOT : SEL_BINARY;

   logic [IDXW-1:0]   dec_idx;
   logic              dec_illegal;
   logic [WIDTH-1:0]  sel_data;
   logic [AWIDTH-1:0] sel_addr;

   if (MODE == SEL_ONEHOT) begin : g_onehot
      sel_dec_t dec;
      always_comb begin
         dec         = onehot_to_idx(MAX_WAYS'(sel), WAYS);
         dec_idx     = dec.idx[IDXW-1:0];
         dec_illegal = dec.illegal;
      end
   end else begin : g_binary
      always_comb begin
         dec_illegal = (32'(sel) >= 32'(WAYS));
         dec_idx     = dec_illegal ? '0 : sel;
      end
   end

   way_select_comb #(
      .WIDTH  (WIDTH),
      .AWIDTH (AWIDTH),
      .WAYS   (WAYS)
   ) u_way_select (
      .way_data_i (way_data),
      .way_addr_i (way_addr),
      .idx_i      (dec_idx),
      .data_o     (sel_data),
      .addr_o     (sel_addr)
   );

   logic              or_valid_q, or_valid_d;
   logic [WIDTH-1:0]  or_data_q,  or_data_d;
   logic [AWIDTH-1:0] or_addr_q,  or_addr_d;
   logic [IDXW-1:0]   or_way_q,   or_way_d;
   logic              sk_valid_q, sk_valid_d;
   logic [WIDTH-1:0]  sk_data_q,  sk_data_d;
   logic [AWIDTH-1:0] sk_addr_q,  sk_addr_d;
   logic [IDXW-1:0]   sk_way_q,   sk_way_d;
   logic              err_q,      err_d;
   logic [ERR_CNT_W-1:0] cnt_q,   cnt_d;

   logic accept;
   logic deliver;

   assign accept  = in_valid && !sk_valid_q;
   assign deliver = or_valid_q && out_ready;

   always_comb begin
      or_valid_d = or_valid_q;
      or_data_d  = or_data_q;
      or_addr_d  = or_addr_q;
      or_way_d   = or_way_q;
      sk_valid_d = sk_valid_q;
      sk_data_d  = sk_data_q;
      sk_addr_d  = sk_addr_q;
      sk_way_d   = sk_way_q;
      err_d      = err_q;
      cnt_d      = cnt_q;

      // accept is impossible while the skid is full, so the first branch
      // never competes with an incoming beat.
      if (sk_valid_q && deliver) begin
         or_data_d  = sk_data_q;
         or_addr_d  = sk_addr_q;
         or_way_d   = sk_way_q;
         sk_valid_d = 1'b0;
      end else if (accept && (!or_valid_q || deliver)) begin
         or_valid_d = 1'b1;
         or_data_d  = sel_data;
         or_addr_d  = sel_addr;
         or_way_d   = dec_idx;
      end else if (accept) begin
         sk_valid_d = 1'b1;
         sk_data_d  = sel_data;
         sk_addr_d  = sel_addr;
         sk_way_d   = dec_idx;
      end else if (deliver) begin
         or_valid_d = 1'b0;
      end

      if (accept && dec_illegal) begin
         err_d = 1'b1;
         if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         or_valid_q <= 1'b0;
         or_data_q  <= '0;
         or_addr_q  <= '0;
         or_way_q   <= '0;
         sk_valid_q <= 1'b0;
         sk_data_q  <= '0;
         sk_addr_q  <= '0;
         sk_way_q   <= '0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
      end else begin
         or_valid_q <= or_valid_d;
         or_data_q  <= or_data_d;
         or_addr_q  <= or_addr_d;
         or_way_q   <= or_way_d;
         sk_valid_q <= sk_valid_d;
         sk_data_q  <= sk_data_d;
         sk_addr_q  <= sk_addr_d;
         sk_way_q   <= sk_way_d;
         err_q      <= err_d;
         cnt_q      <= cnt_d;
      end
   end

   assign in_ready  = !sk_valid_q;
   assign out_valid = or_valid_q;
   assign out_data  = or_data_q;
   assign out_addr  = or_addr_q;
   assign out_way   = or_way_q;
   assign sel_err   = err_q;
   assign err_count = cnt_q;

endmodule

// File: tb/tb_cache_way_sel_pipe.sv
module tb_cache_way_sel_pipe;

   int total = 0;
   int bad   = 0;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // u0: WAYS=2 binary
   logic         iv0, ir0, ov0, or0, se0;
   logic [511:0] wd0;
   logic [63:0]  wa0;
   logic         s0;
   logic [255:0] od0;
   logic [31:0]  oa0;
   logic         ow0;
   logic [7:0]   ec0;

   // u1: WAYS=4 one-hot
   logic          iv1, ir1, ov1, or1, se1;
   logic [1023:0] wd1;
   logic [127:0]  wa1;
   logic [3:0]    s1;
   logic [255:0]  od1;
   logic [31:0]   oa1;
   logic [1:0]    ow1;
   logic [7:0]    ec1;

   // u2: WAYS=3 binary, narrow
   logic        iv2, ir2, ov2, or2, se2;
   logic [47:0] wd2;
   logic [23:0] wa2;
   logic [1:0]  s2;
   logic [15:0] od2;
   logic [7:0]  oa2;
   logic [1:0]  ow2;
   logic [7:0]  ec2;

   cache_way_sel_pipe #(.WIDTH(256), .AWIDTH(32), .WAYS(2), .ONEHOT(0)) u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0),
      .way_data(wd0), .way_addr(wa0), .sel(s0), .out_valid(ov0),
      .out_ready(or0), .out_data(od0), .out_addr(oa0), .out_way(ow0),
      .sel_err(se0), .err_count(ec0));

   cache_way_sel_pipe #(.WIDTH(256), .AWIDTH(32), .WAYS(4), .ONEHOT(1)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
      .way_data(wd1), .way_addr(wa1), .sel(s1), .out_valid(ov1),
      .out_ready(or1), .out_data(od1), .out_addr(oa1), .out_way(ow1),
      .sel_err(se1), .err_count(ec1));

   cache_way_sel_pipe #(.WIDTH(16), .AWIDTH(8), .WAYS(3), .ONEHOT(0)) u2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2),
      .way_data(wd2), .way_addr(wa2), .sel(s2), .out_valid(ov2),
      .out_ready(or2), .out_data(od2), .out_addr(oa2), .out_way(ow2),
      .sel_err(se2), .err_count(ec2));

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] pat(input int w, input int k);
      logic [31:0] t;
      t = 32'((w + 1) * 32'h1000_0000 + k);
      return {8{t}};
   endfunction

   // beat k on u0: way w carries pat(w,k), addr 0x1000*(w+1)+k, sel = k&1
   task automatic drive0(input int k);
      iv0 = 1'b1;
      wd0 = {pat(1, k), pat(0, k)};
      wa0 = {32'(32'h2000 + k), 32'(32'h1000 + k)};
      s0  = 1'(k & 1);
   endtask

   task automatic test_reset;
      total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", ov0); end
      total++; if (ir0 !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", ir0); end
      total++; if (od0 !== 256'd0) begin bad++; $display("FAIL reset_out_data got=%0h exp=0", od0); end
      total++; if (oa0 !== 32'd0 || ow0 !== 1'b0) begin bad++; $display("FAIL reset_addr_way got=%0h/%0b exp=0/0", oa0, ow0); end
      total++; if (se0 !== 1'b0 || ec0 !== 8'd0) begin bad++; $display("FAIL reset_err got=%0b/%0d exp=0/0", se0, ec0); end
   endtask

   task automatic test_basic;
      or0 = 1'b1;
      iv0 = 1'b1;
      wd0 = {{64{4'h5}}, {64{4'hA}}};
      wa0 = {32'h2000, 32'h1000};
      s0  = 1'b1;
      step;
      iv0 = 1'b0;
      total++; if (ov0 !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0b exp=1", ov0); end
      total++; if (od0 !== {64{4'h5}}) begin bad++; $display("FAIL basic_data got=%0h exp=55..55", od0); end
      total++; if (oa0 !== 32'h2000) begin bad++; $display("FAIL basic_addr got=%0h exp=2000", oa0); end
      total++; if (ow0 !== 1'b1) begin bad++; $display("FAIL basic_way got=%0b exp=1", ow0); end
      step;
      total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL basic_drain got=%0b exp=0", ov0); end
   endtask

   task automatic test_stream;
      or0 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         drive0(k);
         total++; if (ir0 !== 1'b1) begin bad++; $display("FAIL stream_in_ready k=%0d got=%0b exp=1", k, ir0); end
         step;
         total++;
         if (ov0 !== 1'b1 || od0 !== pat(k & 1, k) || oa0 !== 32'(32'h1000 * ((k & 1) + 1) + k)) begin
            bad++; $display("FAIL stream_out k=%0d got v=%0b d=%0h a=%0h", k, ov0, od0[31:0], oa0);
         end
      end
      iv0 = 1'b0;
      step;
      total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL stream_drain got=%0b exp=0", ov0); end
   endtask

   task automatic test_backpressure;
      or0 = 1'b0;
      drive0(11);
      step;
      total++; if (od0 !== pat(1, 11) || ir0 !== 1'b1) begin bad++; $display("FAIL bp_b1 got d=%0h r=%0b", od0[31:0], ir0); end
      drive0(12);
      step;
      total++; if (ir0 !== 1'b0) begin bad++; $display("FAIL bp_skid_full got=%0b exp=0", ir0); end
      drive0(13);
      step;
      step;
      total++; if (ov0 !== 1'b1 || od0 !== pat(1, 11) || ow0 !== 1'b1) begin bad++; $display("FAIL bp_hold got v=%0b d=%0h", ov0, od0[31:0]); end
      or0 = 1'b1;
      step;
      total++; if (od0 !== pat(0, 12) || ow0 !== 1'b0 || ir0 !== 1'b1) begin bad++; $display("FAIL bp_b2 got d=%0h r=%0b", od0[31:0], ir0); end
      step;
      iv0 = 1'b0;
      total++; if (ov0 !== 1'b1 || od0 !== pat(1, 13) || oa0 !== 32'h200D) begin bad++; $display("FAIL bp_b3 got d=%0h a=%0h", od0[31:0], oa0); end
      step;
      total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL bp_no_dup got=%0b exp=0", ov0); end
   endtask

   task automatic test_onehot;
      or1 = 1'b1;
      for (int w = 0; w < 4; w++) begin
         wd1[w*256 +: 256] = pat(w, 7);
         wa1[w*32 +: 32]   = 32'(32'h100 * (w + 1));
      end
      iv1 = 1'b1;
      s1  = 4'b0110;
      step;
      total++; if (ow1 !== 2'd1 || od1 !== pat(1, 7) || oa1 !== 32'h200) begin bad++; $display("FAIL oh_multi_sel got way=%0d a=%0h exp way=1", ow1, oa1); end
      total++; if (se1 !== 1'b1 || ec1 !== 8'd1) begin bad++; $display("FAIL oh_multi_err got=%0b/%0d exp=1/1", se1, ec1); end
      s1 = 4'b0000;
      step;
      total++; if (ow1 !== 2'd0 || od1 !== pat(0, 7) || ec1 !== 8'd2) begin bad++; $display("FAIL oh_none got way=%0d cnt=%0d exp=0/2", ow1, ec1); end
      s1 = 4'b1000;
      step;
      iv1 = 1'b0;
      total++; if (ow1 !== 2'd3 || oa1 !== 32'h400 || ec1 !== 8'd2) begin bad++; $display("FAIL oh_legal got way=%0d cnt=%0d exp=3/2", ow1, ec1); end
   endtask

   task automatic test_binary_illegal;
      or2 = 1'b1;
      wd2 = {16'hC3C3, 16'hB2B2, 16'hA1A1};
      wa2 = {8'h33, 8'h22, 8'h11};
      iv2 = 1'b1;
      s2  = 2'd2;
      step;
      total++; if (od2 !== 16'hC3C3 || oa2 !== 8'h33 || ow2 !== 2'd2 || ec2 !== 8'd0) begin bad++; $display("FAIL bin_top_way got d=%0h way=%0d cnt=%0d", od2, ow2, ec2); end
      s2 = 2'd3;
      step;
      iv2 = 1'b0;
      total++; if (od2 !== 16'hA1A1 || ow2 !== 2'd0 || se2 !== 1'b1 || ec2 !== 8'd1) begin bad++; $display("FAIL bin_illegal got d=%0h way=%0d err=%0b cnt=%0d", od2, ow2, se2, ec2); end
   endtask

   task automatic test_saturate;
      or1 = 1'b1;
      iv1 = 1'b1;
      s1  = 4'b0000;
      for (int i = 1; i <= 300; i++) begin
         step;
         if (i == 252) begin
            total++; if (ec1 !== 8'd254) begin bad++; $display("FAIL sat_pre got=%0d exp=254", ec1); end
         end
         if (i == 253) begin
            total++; if (ec1 !== 8'd255) begin bad++; $display("FAIL sat_hit got=%0d exp=255", ec1); end
         end
      end
      total++; if (ec1 !== 8'd255 || se1 !== 1'b1) begin bad++; $display("FAIL sat_hold got=%0d/%0b exp=255/1", ec1, se1); end
      s1 = 4'b0100;
      step;
      iv1 = 1'b0;
      total++; if (ow1 !== 2'd2 || ec1 !== 8'd255 || se1 !== 1'b1) begin bad++; $display("FAIL sat_legal got way=%0d cnt=%0d err=%0b", ow1, ec1, se1); end
   endtask

   task automatic test_reset_mid;
      or0 = 1'b0;
      drive0(21);
      step;
      drive0(22);
      step;
      drive0(23);
      total++; if (ir0 !== 1'b0 || ov0 !== 1'b1) begin bad++; $display("FAIL rst_fill got r=%0b v=%0b exp=0/1", ir0, ov0); end
      rst_n = 1'b0;
      #1;
      total++; if (ov0 !== 1'b0 || ir0 !== 1'b1 || od0 !== 256'd0) begin bad++; $display("FAIL rst_async got v=%0b r=%0b", ov0, ir0); end
      total++; if (ec1 !== 8'd0 || se1 !== 1'b0) begin bad++; $display("FAIL rst_err got=%0d/%0b exp=0/0", ec1, se1); end
      iv0 = 1'b0;
      or0 = 1'b1;
      #1;
      rst_n = 1'b1;
      step;
      total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL rst_no_partial got=%0b exp=0", ov0); end
      drive0(31);
      step;
      iv0 = 1'b0;
      total++; if (ov0 !== 1'b1 || od0 !== pat(1, 31) || oa0 !== 32'h201F) begin bad++; $display("FAIL rst_new_beat got v=%0b d=%0h", ov0, od0[31:0]); end
   endtask

   initial begin
      rst_n = 1'b0;
      iv0 = 1'b0; or0 = 1'b0; wd0 = '0; wa0 = '0; s0 = '0;
      iv1 = 1'b0; or1 = 1'b0; wd1 = '0; wa1 = '0; s1 = '0;
      iv2 = 1'b0; or2 = 1'b0; wd2 = '0; wa2 = '0; s2 = '0;
      step;
      step;
      test_reset;
      rst_n = 1'b1;
      step;
      test_basic;
      test_stream;
      test_backpressure;
      test_onehot;
      test_binary_illegal;
      test_saturate;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
